// File: rtl/axi4s_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_PORTS AXI4-Stream sources share one downstream stream.
// Latency: 1 cycle arbitration from IDLE, then zero-latency combinational pass-through per beat.
// Backpressure: s_tready_i is forwarded only to the granted source; all other sources see ready=0.
// Optional macro AXI4S_ARB_BACK_TO_BACK_EN: re-arbitrate on the tlast beat to remove the inter-packet bubble.
module axi4s_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int AXI_WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORTS*AXI_WIDTH-1:0] m_tdata_i,
  input  logic [NUM_PORTS-1:0]           m_tvalid_i,
  output logic [NUM_PORTS-1:0]           m_tready_o,
  input  logic [NUM_PORTS-1:0]           m_tlast_i,
  output logic [AXI_WIDTH-1:0]           s_tdata_o,
  output logic                           s_tvalid_o,
  input  logic                           s_tready_i,
  output logic                           s_tlast_o,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_o,
  output logic                           busy_o
);

  localparam int GRANT_W = $clog2(NUM_PORTS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state;
  logic [GRANT_W-1:0] grant_r;
  logic [GRANT_W-1:0] last_grant_r;
  logic               locked;
  logic               pkt_end;

  // First requesting port searching cyclically from last+1, with last itself checked at the end.
  function automatic logic [GRANT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [GRANT_W-1:0]   last);
    logic [GRANT_W-1:0] pick;
    logic [GRANT_W-1:0] idx_g;
    logic               found;
    int                 idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx   = (int'(last) + i) % NUM_PORTS;
      idx_g = GRANT_W'(idx);
      if (!found && req[idx_g]) begin
        pick  = idx_g;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign locked  = (state == ST_LOCKED);
  assign busy_o  = locked;
  assign grant_o = grant_r;

  // Forward the granted source downstream and route ready back only to that source.
  always_comb begin
    s_tdata_o  = '0;
    s_tlast_o  = 1'b0;
    s_tvalid_o = 1'b0;
    m_tready_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_r == GRANT_W'(k)) begin
        s_tdata_o     = m_tdata_i[k*AXI_WIDTH +: AXI_WIDTH];
        s_tlast_o     = m_tlast_i[k];
        s_tvalid_o    = locked && m_tvalid_i[k];
        m_tready_o[k] = locked && s_tready_i;
      end
    end
  end

  assign pkt_end = s_tvalid_o && s_tready_i && s_tlast_o;

  // Grant state machine: lock on a packet, release (or hand over) on the accepted tlast beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= GRANT_W'(NUM_PORTS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_tvalid_i) begin
            grant_r <= rr_pick(m_tvalid_i, last_grant_r);
            state   <= ST_LOCKED;
          end
        end
        default: begin
          if (pkt_end) begin
            last_grant_r <= grant_r;
`ifdef AXI4S_ARB_BACK_TO_BACK_EN
            if (|m_tvalid_i) begin
              grant_r <= rr_pick(m_tvalid_i, grant_r);
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// Directed bench for axi4s_rr_arbiter with four 64-bit sources.
// Sources are simple packet generators advanced on observed handshakes.
// Accepted downstream beats are logged with port, data, tlast and cycle number.
module tb_axi4s_rr_arbiter;

  localparam int NP = 4;
  localparam int W  = 64;
`ifdef AXI4S_ARB_BACK_TO_BACK_EN
  localparam int PKT_GAP = 1;
`else
  localparam int PKT_GAP = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*W-1:0] m_tdata = '0;
  logic [NP-1:0]   m_tvalid = '0;
  logic [NP-1:0]   m_tready;
  logic [NP-1:0]   m_tlast = '0;
  logic [W-1:0]    s_tdata;
  logic            s_tvalid;
  logic            s_tready = 1'b1;
  logic            s_tlast;
  logic [1:0]      grant;
  logic            busy;

  axi4s_rr_arbiter #(.NUM_PORTS(NP), .AXI_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_tdata_i(m_tdata), .m_tvalid_i(m_tvalid), .m_tready_o(m_tready), .m_tlast_i(m_tlast),
    .s_tdata_o(s_tdata), .s_tvalid_o(s_tvalid), .s_tready_i(s_tready), .s_tlast_o(s_tlast),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         src_len  [NP];
  int         src_pkts [NP];
  int         src_beat [NP];
  logic [W-1:0] src_dat [NP];
  logic       src_gap  [NP];

  int           log_port[$];
  logic [W-1:0] log_dat[$];
  logic         log_last[$];
  int           log_cyc[$];

  task automatic drive();
    for (int k = 0; k < NP; k++) begin
      m_tvalid[k]        = (src_pkts[k] > 0) && !src_gap[k];
      m_tdata[k*W +: W]  = src_dat[k];
      m_tlast[k]         = (src_beat[k] == src_len[k] - 1);
    end
  endtask

  task automatic clear_log();
    log_port.delete(); log_dat.delete(); log_last.delete(); log_cyc.delete();
  endtask

  // One clock: sample handshakes before the edge, advance sources after it.
  task automatic tick();
    logic [NP-1:0] fire;
    fire = m_tvalid & m_tready;
    if (s_tvalid && s_tready) begin
      log_port.push_back(int'(grant));
      log_dat.push_back(s_tdata);
      log_last.push_back(s_tlast);
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NP; k++) begin
      if (fire[k]) begin
        src_dat[k]++;
        if (src_beat[k] == src_len[k] - 1) begin
          src_beat[k] = 0;
          src_pkts[k]--;
        end else begin
          src_beat[k]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic set_src(input int k, input int len, input int pkts, input logic [W-1:0] base);
    src_len[k] = len; src_pkts[k] = pkts; src_beat[k] = 0; src_dat[k] = base; src_gap[k] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    s_tready = 1'b1;
    for (int k = 0; k < NP; k++) set_src(k, 1, 0, '0);
    drive();
    repeat (n) tick();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_tready = 1'b1;
    for (int k = 0; k < NP; k++) set_src(k, 1, 0, '0);
    drive();
    repeat (3) tick();
    n_checks++; if (s_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", s_tvalid); end
    n_checks++; if (m_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready: got %b expected 0000", m_tready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    rst_n = 1'b1;
    clear_log();
    set_src(2, 4, 1, 64'h20);
    drive();
    #1;
    n_checks++; if (s_tvalid !== 1'b0) begin n_fail++; $display("FAIL first_req_bubble: tvalid got %b expected 0", s_tvalid); end
    tick();
    for (int b = 0; b < 4; b++) begin
      n_checks++; if (s_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid[%0d]: got %b expected 1", b, s_tvalid); end
      n_checks++; if (s_tdata !== 64'h20 + 64'(b)) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", b, s_tdata, 64'h20 + 64'(b)); end
      n_checks++; if (s_tlast !== (b == 3)) begin n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", b, s_tlast, (b == 3)); end
      n_checks++; if (grant !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant[%0d]: got grant %0d busy %b expected 2 1", b, grant, busy); end
      n_checks++; if (m_tready !== 4'b0100) begin n_fail++; $display("FAIL single_tready[%0d]: got %b expected 0100", b, m_tready); end
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release: busy got %b expected 0", busy); end
  endtask

  task automatic test_all_ports();
    int guard;
    int p, n, b;
    do_reset(2);
    for (int k = 0; k < NP; k++) set_src(k, 2, 3, 64'((k + 1) * 256));
    drive();
    #1;
    guard = 0;
    while (log_port.size() < 12 && guard < 80) begin tick(); guard++; end
    n_checks++; if (log_port.size() < 12) begin n_fail++; $display("FAIL rr_beats: got %0d beats expected 12", log_port.size()); end
    for (int i = 0; i < 12 && i < log_port.size(); i++) begin
      p = (i / 2) % 4; n = i / 8; b = i % 2;
      n_checks++; if (log_port[i] !== p) begin n_fail++; $display("FAIL rr_port[%0d]: got %0d expected %0d", i, log_port[i], p); end
      n_checks++; if (log_dat[i] !== 64'((p + 1) * 256 + n * 2 + b)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, log_dat[i], 64'((p + 1) * 256 + n * 2 + b)); end
      n_checks++; if (log_last[i] !== (b == 1)) begin n_fail++; $display("FAIL rr_last[%0d]: got %b expected %b", i, log_last[i], (b == 1)); end
      if (i > 0) begin
        n_checks++;
        if (log_cyc[i] - log_cyc[i-1] !== ((b == 0) ? PKT_GAP : 1)) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected %0d", i, log_cyc[i] - log_cyc[i-1], (b == 0) ? PKT_GAP : 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(2);
    set_src(1, 4, 1, 64'h1000);
    set_src(3, 2, 1, 64'h3000);
    drive();
    #1;
    tick();
    tick();
    s_tready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (m_tready !== 4'b0000) begin n_fail++; $display("FAIL stall_tready[%0d]: got %b expected 0000", c, m_tready); end
      n_checks++; if (s_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall_tvalid[%0d]: got %b expected 1", c, s_tvalid); end
      n_checks++; if (s_tdata !== 64'h1001) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected 1001", c, s_tdata); end
      n_checks++; if (grant !== 2'd1) begin n_fail++; $display("FAIL stall_grant[%0d]: got %0d expected 1", c, grant); end
      tick();
    end
    s_tready = 1'b1;
    #1;
    repeat (12) tick();
    n_checks++; if (log_port.size() !== 6) begin n_fail++; $display("FAIL stall_beats: got %0d expected 6", log_port.size()); end
    for (int i = 0; i < 6 && i < log_port.size(); i++) begin
      n_checks++;
      if (log_port[i] !== ((i < 4) ? 1 : 3) || log_dat[i] !== ((i < 4) ? 64'h1000 + 64'(i) : 64'h3000 + 64'(i - 4))) begin
        n_fail++; $display("FAIL stall_order[%0d]: got port %0d data %h", i, log_port[i], log_dat[i]);
      end
    end
  endtask

  task automatic test_gap();
    do_reset(2);
    set_src(0, 3, 1, 64'hA00);
    set_src(1, 1, 1, 64'hB00);
    drive();
    #1;
    tick();
    tick();
    src_gap[0] = 1'b1;
    drive();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++; if (grant !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_grant[%0d]: got grant %0d busy %b expected 0 1", c, grant, busy); end
      n_checks++; if (s_tvalid !== 1'b0) begin n_fail++; $display("FAIL gap_tvalid[%0d]: got %b expected 0", c, s_tvalid); end
      n_checks++; if (m_tready[1] !== 1'b0) begin n_fail++; $display("FAIL gap_port1_ready[%0d]: got %b expected 0", c, m_tready[1]); end
      tick();
    end
    src_gap[0] = 1'b0;
    drive();
    #1;
    repeat (10) tick();
    n_checks++; if (log_port.size() !== 4) begin n_fail++; $display("FAIL gap_beats: got %0d expected 4", log_port.size()); end
    for (int i = 0; i < 4 && i < log_port.size(); i++) begin
      n_checks++;
      if (log_port[i] !== ((i < 3) ? 0 : 1) || log_dat[i] !== ((i < 3) ? 64'hA00 + 64'(i) : 64'hB00) || log_last[i] !== (i >= 2)) begin
        n_fail++; $display("FAIL gap_order[%0d]: got port %0d data %h last %b", i, log_port[i], log_dat[i], log_last[i]);
      end
    end
  endtask

  task automatic test_single_beat();
    int exp_p;
    do_reset(2);
    set_src(0, 1, 2, 64'hC0);
    set_src(3, 1, 2, 64'hD0);
    drive();
    #1;
    repeat (15) tick();
    n_checks++; if (log_port.size() !== 4) begin n_fail++; $display("FAIL sb_beats: got %0d expected 4", log_port.size()); end
    for (int i = 0; i < 4 && i < log_port.size(); i++) begin
      exp_p = (i % 2 == 0) ? 0 : 3;
      n_checks++;
      if (log_port[i] !== exp_p || log_dat[i] !== ((exp_p == 0) ? 64'hC0 : 64'hD0) + 64'(i / 2) || log_last[i] !== 1'b1) begin
        n_fail++; $display("FAIL sb_order[%0d]: got port %0d data %h last %b expected port %0d", i, log_port[i], log_dat[i], log_last[i], exp_p);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    set_src(3, 5, 1, 64'hE0);
    drive();
    #1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tick();
    n_checks++; if (s_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got tvalid %b busy %b expected 0 0", s_tvalid, busy); end
    n_checks++; if (m_tready !== 4'b0000 || grant !== 2'd0) begin n_fail++; $display("FAIL midrst_outs: got tready %b grant %0d expected 0000 0", m_tready, grant); end
    set_src(0, 1, 1, 64'hF0);
    rst_n = 1'b1;
    drive();
    #1;
    tick();
    n_checks++; if (grant !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_prio: got grant %0d busy %b expected 0 1", grant, busy); end
    n_checks++; if (s_tdata !== 64'hF0 || s_tvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_data: got %h valid %b expected f0 1", s_tdata, s_tvalid); end
  endtask

  initial begin
    test_reset();
    test_all_ports();
    test_stall();
    test_gap();
    test_single_beat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
